// File: rtl/spu_pair_issue.sv
// spu_pair_issue: SPU-Lite issue stage, splits an A/B pair onto the even/odd pipes (optional SPU_ISSUE_PERF_EN counters).
// Latency: 1 cycle, registered outputs; a hazarded pair issues over 2 cycles.
// Backpressure: in_ready drops in SECOND, on stall/flush and once halted; stall freezes the stage.
module spu_pair_issue #(
    parameter int OPW   = 7,
    parameter int REGW  = 7,
    parameter int INSTW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INSTW-1:0] instr_a,
    input  logic [INSTW-1:0] instr_b,
    input  logic             stall,
    input  logic             flush,
    output logic             even_valid,
    output logic [OPW-1:0]   even_op,
    output logic [REGW-1:0]  even_rt,
    output logic [REGW-1:0]  even_ra,
    output logic [REGW-1:0]  even_rb,
    output logic             odd_valid,
    output logic [OPW-1:0]   odd_op,
    output logic [REGW-1:0]  odd_rt,
    output logic [REGW-1:0]  odd_ra,
    output logic [REGW-1:0]  odd_rb,
    output logic             halted
`ifdef SPU_ISSUE_PERF_EN
    ,
    output logic [31:0]      dual_cnt,
    output logic [31:0]      split_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int USED = OPW + 3 * REGW;
    localparam logic [OPW-1:0] OP_STOP = OPW'(92);

    typedef enum logic {ST_ACCEPT, ST_SECOND} state_t;
    typedef enum logic [1:0] {CL_ILL, CL_EVEN, CL_ODD} cls_t;

    // Field order mirrors the instruction word, LSB first: op, rt, ra, rb.
    typedef struct packed {
        logic [REGW-1:0] rb;
        logic [REGW-1:0] ra;
        logic [REGW-1:0] rt;
        logic [OPW-1:0]  op;
    } inst_t;

    function automatic cls_t classify(input logic [OPW-1:0] op);
        int unsigned v;
        v = 32'(op);
        if (v == 32'd93) return CL_EVEN;
        if (v == 32'd94) return CL_ODD;
        if (v >= 32'd1 && v <= 32'd66 && v != 32'd8) return CL_EVEN;
        if (v >= 32'd67 && v <= 32'd92) return CL_ODD;
        return CL_ILL;
    endfunction

    function automatic logic writes_rt(input logic [OPW-1:0] op);
        int unsigned v;
        v = 32'(op);
        if (classify(op) == CL_ILL) return 1'b0;
        if (v >= 32'd82 && v <= 32'd85) return 1'b0;
        if (v >= 32'd88 && v <= 32'd94) return 1'b0;
        return 1'b1;
    endfunction

    state_t state;
    inst_t  hold_q;
    inst_t  a, b;
    cls_t   a_cls, b_cls, h_cls;
    logic   raw, hazard, a_stop, accept;
    logic   ev_issue, od_issue, split, issue_stop;
    inst_t  ev_src, od_src;
    logic   unused_bits;

    assign a      = instr_a[USED-1:0];
    assign b      = instr_b[USED-1:0];
    assign a_cls  = classify(a.op);
    assign b_cls  = classify(b.op);
    assign h_cls  = classify(hold_q.op);
    assign a_stop = (a.op == OP_STOP);
    assign raw    = writes_rt(a.op) && ((b.ra == a.rt) || (b.rb == a.rt));
    // Illegal slots never take part in a hazard; they just vanish.
    assign hazard = (a_cls != CL_ILL) && (b_cls != CL_ILL) && ((a_cls == b_cls) || raw);

    assign in_ready    = (state == ST_ACCEPT) && !stall && !halted && !flush;
    assign accept      = in_valid && in_ready;
    assign unused_bits = ^{instr_a[INSTW-1:USED], instr_b[INSTW-1:USED]};

    always_comb begin
        ev_issue = 1'b0;
        od_issue = 1'b0;
        ev_src   = a;
        od_src   = a;
        split    = 1'b0;
        if (state == ST_SECOND) begin
            if (!stall && !flush) begin
                if (h_cls == CL_EVEN) begin
                    ev_issue = 1'b1;
                    ev_src   = hold_q;
                end
                if (h_cls == CL_ODD) begin
                    od_issue = 1'b1;
                    od_src   = hold_q;
                end
            end
        end else if (accept) begin
            if (a_cls == CL_EVEN) ev_issue = 1'b1;
            if (a_cls == CL_ODD)  od_issue = 1'b1;
            if (!a_stop) begin
                if (hazard) begin
                    split = 1'b1;
                end else begin
                    if (b_cls == CL_EVEN) begin
                        ev_issue = 1'b1;
                        ev_src   = b;
                    end
                    if (b_cls == CL_ODD) begin
                        od_issue = 1'b1;
                        od_src   = b;
                    end
                end
            end
        end
    end

    assign issue_stop = (ev_issue && ev_src.op == OP_STOP) || (od_issue && od_src.op == OP_STOP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_ACCEPT;
            hold_q     <= '0;
            even_valid <= 1'b0;
            even_op    <= '0;
            even_rt    <= '0;
            even_ra    <= '0;
            even_rb    <= '0;
            odd_valid  <= 1'b0;
            odd_op     <= '0;
            odd_rt     <= '0;
            odd_ra     <= '0;
            odd_rb     <= '0;
            halted     <= 1'b0;
        end else if (flush) begin
            // Dropping back to ACCEPT is what discards the held B.
            state      <= ST_ACCEPT;
            even_valid <= 1'b0;
            odd_valid  <= 1'b0;
        end else if (!stall) begin
            even_valid <= ev_issue;
            odd_valid  <= od_issue;
            if (ev_issue) begin
                even_op <= ev_src.op;
                even_rt <= ev_src.rt;
                even_ra <= ev_src.ra;
                even_rb <= ev_src.rb;
            end
            if (od_issue) begin
                odd_op <= od_src.op;
                odd_rt <= od_src.rt;
                odd_ra <= od_src.ra;
                odd_rb <= od_src.rb;
            end
            if (issue_stop) halted <= 1'b1;
            if (split) hold_q <= b;
            state <= split ? ST_SECOND : ST_ACCEPT;
        end
    end

`ifdef SPU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            dual_cnt  <= '0;
            split_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (even_valid && odd_valid) dual_cnt <= dual_cnt + 32'd1;
            if (split)                   split_cnt <= split_cnt + 32'd1;
            if (stall)                   stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spu_pair_issue.sv
// Bench for spu_pair_issue: directed steps plus randomized pairs against a rule-level model.
module tb_spu_pair_issue;
    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [31:0] instr_a, instr_b;
    logic        in_ready, even_valid, odd_valid, halted;
    logic [6:0]  even_op, even_rt, even_ra, even_rb;
    logic [6:0]  odd_op, odd_rt, odd_ra, odd_rb;

    always #5 clk = ~clk;

    spu_pair_issue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr_a(instr_a), .instr_b(instr_b), .stall(stall), .flush(flush),
        .even_valid(even_valid), .even_op(even_op), .even_rt(even_rt),
        .even_ra(even_ra), .even_rb(even_rb),
        .odd_valid(odd_valid), .odd_op(odd_op), .odd_rt(odd_rt),
        .odd_ra(odd_ra), .odd_rb(odd_rb), .halted(halted)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: class table, writes-rt table and the architectural view of the stage.
    int          cls_tab[128];   // 0 illegal, 1 even, 2 odd
    bit          wr_tab[128];
    bit          m_held, m_halted, m_ev, m_od;
    logic [31:0] m_hold, m_einst, m_oinst;

    function automatic logic [31:0] mk(input int op, input int rt, input int ra, input int rb);
        return {4'b0, 7'(rb), 7'(ra), 7'(rt), 7'(op)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hazard(input logic [31:0] x, input logic [31:0] y);
        int ca, cb;
        ca = cls_tab[int'(x[6:0])];
        cb = cls_tab[int'(y[6:0])];
        if (ca == 0 || cb == 0) return 1'b0;
        if (ca == cb) return 1'b1;
        return wr_tab[int'(x[6:0])] && (y[20:14] == x[13:7] || y[27:21] == x[13:7]);
    endfunction

    task automatic m_issue(input logic [31:0] x);
        int op;
        op = int'(x[6:0]);
        if (cls_tab[op] == 1) begin m_ev = 1'b1; m_einst = x; end
        if (cls_tab[op] == 2) begin m_od = 1'b1; m_oinst = x; end
        if (op == 92) m_halted = 1'b1;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".even_valid"}, 32'(even_valid), 32'(m_ev));
        chk({tag, ".odd_valid"},  32'(odd_valid),  32'(m_od));
        chk({tag, ".halted"},     32'(halted),     32'(m_halted));
        if (m_ev) begin
            chk({tag, ".even_op"}, 32'(even_op), 32'(m_einst[6:0]));
            chk({tag, ".even_rt"}, 32'(even_rt), 32'(m_einst[13:7]));
            chk({tag, ".even_ra"}, 32'(even_ra), 32'(m_einst[20:14]));
            chk({tag, ".even_rb"}, 32'(even_rb), 32'(m_einst[27:21]));
        end
        if (m_od) begin
            chk({tag, ".odd_op"}, 32'(odd_op), 32'(m_oinst[6:0]));
            chk({tag, ".odd_rt"}, 32'(odd_rt), 32'(m_oinst[13:7]));
            chk({tag, ".odd_ra"}, 32'(odd_ra), 32'(m_oinst[20:14]));
            chk({tag, ".odd_rb"}, 32'(odd_rb), 32'(m_oinst[27:21]));
        end
    endtask

    task automatic step(input string tag, input bit v, input logic [31:0] a, input logic [31:0] b,
                        input bit st, input bit fl);
        bit exp_rdy;
        @(negedge clk);
        in_valid = v; instr_a = a; instr_b = b; stall = st; flush = fl;
        #1;
        exp_rdy = !m_held && !st && !m_halted && !fl;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (fl) begin
            m_ev = 1'b0; m_od = 1'b0; m_held = 1'b0;
        end else if (!st) begin
            m_ev = 1'b0; m_od = 1'b0;
            if (m_held) begin
                m_issue(m_hold);
                m_held = 1'b0;
            end else if (v && exp_rdy) begin
                m_issue(a);
                if (a[6:0] != 7'd92) begin
                    if (m_hazard(a, b)) begin m_held = 1'b1; m_hold = b; end
                    else m_issue(b);
                end
            end
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b1; stall = 1'b1; flush = 1'b1;
        instr_a = mk(1, 1, 2, 3); instr_b = mk(80, 4, 5, 6);
        @(posedge clk);
        #1;
        m_held = 1'b0; m_halted = 1'b0; m_ev = 1'b0; m_od = 1'b0;
        m_hold = '0; m_einst = '0; m_oinst = '0;
        chk("rst.even_valid", 32'(even_valid), 32'd0);
        chk("rst.odd_valid",  32'(odd_valid),  32'd0);
        chk("rst.halted",     32'(halted),     32'd0);
        chk("rst.even_fields", {4'b0, even_rb, even_ra, even_rt, even_op}, 32'd0);
        chk("rst.odd_fields",  {4'b0, odd_rb, odd_ra, odd_rt, odd_op},     32'd0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            if (i == 93)                               cls_tab[i] = 1;
            else if (i == 94)                          cls_tab[i] = 2;
            else if (i >= 1 && i <= 66 && i != 8)      cls_tab[i] = 1;
            else if (i >= 67 && i <= 92)               cls_tab[i] = 2;
            else                                       cls_tab[i] = 0;
            wr_tab[i] = (cls_tab[i] != 0) && !((i >= 82 && i <= 85) || (i >= 88 && i <= 94));
        end
        reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        instr_a = '0; instr_b = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Dual issue
        step("dual", 1, mk(1, 3, 1, 2), mk(80, 4, 5, 0), 0, 0);
        chk("dual.even_op_const", 32'(even_op), 32'd1);
        chk("dual.odd_op_const",  32'(odd_op),  32'd80);
        chk("dual.odd_rt_const",  32'(odd_rt),  32'd4);
        step("idle1", 0, '0, '0, 0, 0);

        // Structural split
        step("struct1", 1, mk(1, 3, 1, 2), mk(17, 6, 7, 8), 0, 0);
        chk("struct1.even_op_const", 32'(even_op), 32'd1);
        step("struct2", 1, mk(2, 1, 1, 1), mk(3, 1, 1, 1), 0, 0);
        chk("struct2.even_op_const", 32'(even_op), 32'd17);
        chk("struct2.odd_valid_const", 32'(odd_valid), 32'd0);

        // RAW split
        step("raw1", 1, mk(1, 9, 1, 2), mk(72, 10, 9, 3), 0, 0);
        step("raw2", 0, '0, '0, 0, 0);
        chk("raw2.odd_op_const", 32'(odd_op), 32'd72);

        // Stall in SECOND, then flush drops the held B
        step("sf1", 1, mk(5, 3, 1, 2), mk(20, 6, 7, 8), 0, 0);
        for (int i = 0; i < 3; i++) step("sf_stall", 1, mk(1, 1, 1, 1), mk(80, 2, 2, 2), 1, 0);
        chk("sf_stall.even_op_const", 32'(even_op), 32'd5);
        step("sf_flush", 1, mk(1, 1, 1, 1), mk(80, 2, 2, 2), 1, 1);
        step("sf_after", 0, '0, '0, 0, 0);

        // Illegal slots
        step("ill1", 1, mk(0, 1, 2, 3), mk(95, 4, 5, 6), 0, 0);
        step("ill2", 1, mk(8, 1, 2, 3), mk(1, 1, 1, 1), 0, 0);
        chk("ill2.even_op_const", 32'(even_op), 32'd1);

        // Randomized traffic (STOP excluded here)
        for (int n = 0; n < 400; n++) begin
            int oa, ob;
            oa = int'($urandom_range(0, 127)); if (oa == 92) oa = 91;
            ob = int'($urandom_range(0, 127)); if (ob == 92) ob = 91;
            step("rand", ($urandom_range(0, 3) != 0),
                 mk(oa, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))),
                 mk(ob, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        // STOP in slot A: B dropped, stage halts until reset
        step("stop1", 1, mk(92, 1, 2, 3), mk(1, 4, 5, 6), 0, 0);
        chk("stop1.odd_op_const", 32'(odd_op), 32'd92);
        chk("stop1.halted_const", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) step("halted", 1, mk(1, 3, 1, 2), mk(80, 4, 5, 0), 0, i == 1);
        do_reset();

        // STOP arriving as the held B
        step("stopb1", 1, mk(80, 1, 2, 3), mk(92, 0, 0, 0), 0, 0);
        step("stopb2", 0, '0, '0, 0, 0);
        chk("stopb2.halted_const", 32'(halted), 32'd1);
        step("stopb3", 1, mk(1, 3, 1, 2), mk(80, 4, 5, 0), 0, 0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
